// File: rtl/hack_pkg.sv
// Shared constants, instruction field positions and decode helper for the Hack CPU core.
package hack_pkg;

  localparam int WORD_W = 16;
  localparam int PC_W   = 15;

  localparam int I_TYPE = 15;
  localparam int I_A    = 12;
  localparam int I_C_HI = 11;
  localparam int I_C_LO = 6;
  localparam int I_D_HI = 5;
  localparam int I_D_LO = 3;
  localparam int I_J_HI = 2;
  localparam int I_J_LO = 0;

  typedef struct packed {
    logic is_c;
    logic a;
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
    logic d_a;
    logic d_d;
    logic d_m;
    logic j_lt;
    logic j_eq;
    logic j_gt;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [WORD_W-1:0] instr);
    ctrl_t c;
    c.is_c = instr[I_TYPE];
    c.a    = instr[I_A];
    {c.zx, c.nx, c.zy, c.ny, c.f, c.no} = instr[I_C_HI:I_C_LO];
    {c.d_a, c.d_d, c.d_m}               = instr[I_D_HI:I_D_LO];
    {c.j_lt, c.j_eq, c.j_gt}            = instr[I_J_HI:I_J_LO];
    return c;
  endfunction

endpackage

// File: rtl/hack_alu.sv
// Hack ALU: zero/negate each operand, add or AND, optionally negate the result.
module hack_alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] xa;
  logic [15:0] ya;
  logic [15:0] res;

  always_comb begin
    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    xa  = zx ? 16'h0000 : x;
    ya  = zy ? 16'h0000 : y;
    if (nx) xa = ~xa;
    if (ny) ya = ~ya;
    res = f ? (xa + ya) : (xa & ya);
    if (no) res = ~res;
  end

  assign out = res;
  assign zr  = (res == 16'h0000);
  assign ng  = res[15];

endmodule

// File: rtl/hack_pc.sv
// Program counter register: synchronous reset has priority over load, load over increment.
module hack_pc #(
  parameter int PC_W         = 15,
  parameter int RESET_VECTOR = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_value,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset)     pc <= PC_W'(RESET_VECTOR);
    else if (load) pc <= load_value;
    else if (inc)  pc <= pc + PC_W'(1);
  end

endmodule

// File: rtl/hack_cpu_core.sv
// Hack CPU core: decode, A/D registers, PC and ALU hookup, one instruction per clock.
// Optional halt detector enabled by defining HACK_CPU_HALT_DETECT_EN.
module hack_cpu_core
  import hack_pkg::*;
#(
  parameter int PC_W         = 15,
  parameter int RESET_VECTOR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] instruction,
  input  logic [WORD_W-1:0] inM,
  output logic [WORD_W-1:0] outM,
  output logic              writeM,
  output logic [PC_W-1:0]   addressM,
  output logic [PC_W-1:0]   pc
`ifdef HACK_CPU_HALT_DETECT_EN
  ,
  output logic              halted
`endif
);

  ctrl_t             ctrl;
  logic [WORD_W-1:0] a_reg;
  logic [WORD_W-1:0] d_reg;
  logic [WORD_W-1:0] alu_y;
  logic              zr;
  logic              ng;
  logic              jmp;

  assign ctrl  = decode(instruction);
  // The a=0 path never looks at inM, so an unknown RAM value cannot leak in.
  assign alu_y = ctrl.a ? inM : a_reg;

  hack_alu u_alu (
    .x  (d_reg),
    .y  (alu_y),
    .zx (ctrl.zx),
    .nx (ctrl.nx),
    .zy (ctrl.zy),
    .ny (ctrl.ny),
    .f  (ctrl.f),
    .no (ctrl.no),
    .out(outM),
    .zr (zr),
    .ng (ng)
  );

  assign writeM   = ctrl.is_c & ctrl.d_m & ~reset;
  assign addressM = a_reg[PC_W-1:0];
  assign jmp      = ctrl.is_c & ((ctrl.j_lt & ng) | (ctrl.j_eq & zr) | (ctrl.j_gt & ~ng & ~zr));

  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg <= '0;
      d_reg <= '0;
    end else if (!ctrl.is_c) begin
      a_reg <= {1'b0, instruction[I_TYPE-1:0]};
    end else begin
      if (ctrl.d_a) a_reg <= outM;
      if (ctrl.d_d) d_reg <= outM;
    end
  end

  // Jump target is the pre-edge A, even when the same instruction also writes A.
  hack_pc #(
    .PC_W        (PC_W),
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc (
    .clock     (clock),
    .reset     (reset),
    .load      (jmp),
    .inc       (1'b1),
    .load_value(addressM),
    .pc        (pc)
  );

`ifdef HACK_CPU_HALT_DETECT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (ctrl.is_c && ctrl.j_lt && ctrl.j_eq && ctrl.j_gt && (addressM == pc)) begin
      halted <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/hack_cpu_core.md
Name: hack_cpu_core

Overview:
- Hack CPU datapath and control, one instruction per clock.
- Decodes the 16-bit instruction, holds the A and D registers and the PC, and drives the existing ALU.
- Consumes ALU out/zr/ng to produce data-memory write traffic and jump decisions.
- Sits between instruction ROM / data RAM and the ALU, which it instantiates unchanged.

Parameters:
- PC_W, 15, width of pc and addressM.
- RESET_VECTOR, 0, pc value loaded on reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- instruction  in  16  current instruction, ROM[pc].
- inM  in  16  data RAM read value at addressM.
- outM  out  16  ALU result (combinational).
- writeM  out  1  RAM write enable for the current cycle.
- addressM  out  PC_W  current A register bits [PC_W-1:0].
- pc  out  PC_W  address of the next instruction.
- halted  out  1  exists only with HALT_DETECT_EN.

Behaviour:
- Decode:
  - instruction[15]=0 is an A-instruction: A <= {1'b0, instruction[14:0]} at the clock edge.
  - instruction[15]=1 is a C-instruction:
    - a = instruction[12].
    - zx,nx,zy,ny,f,no = instruction[11:6].
    - d1(A), d2(D), d3(M) = instruction[5:3].
    - j1(<0), j2(=0), j3(>0) = instruction[2:0].
- ALU hookup: x = D; y = a ? inM : A. outM = ALU out. zr and ng are taken directly from the ALU.
- Register writes (C-instruction only):
  - A <= outM if d1.
  - D <= outM if d2.
  - writeM = d3 & ~reset, combinational.
  - A-instructions never write D or M.
- addressM always reflects the pre-edge A. When d1 and d3 are both set, the memory write uses the old A and A takes the new value after the edge.
- Jump condition: jmp = instruction[15] & ((j1&ng) | (j2&zr) | (j3&~ng&~zr)).
- PC update at each edge:
  - reset: pc <= RESET_VECTOR.
  - else if jmp: pc <= old A[PC_W-1:0].
  - else: pc <= pc+1, wrapping from 2^PC_W-1 to 0.
- Same-cycle conflicts: a jump plus a write to A targets the OLD A. The upper A bit is ignored for jump targets.
- Reset:
  - A, D, pc are set to 0 / RESET_VECTOR at the first edge with reset=1.
  - writeM is forced 0 while reset=1, including mid-instruction.
  - outM stays combinational (a don't-care during reset).
  - The first instruction executes on the first edge with reset=0.
- Latency: outM/writeM/addressM are valid in the same cycle as the instruction. Register and pc effects are visible after one edge.
- Unknown inM while a=0 must not affect any result.

Optional Feature:
- Macro: HACK_CPU_HALT_DETECT_EN.
- When defined:
  - The halted port exists.
  - halted is a registered output, 0 on reset.
  - It is set to 1 at an edge where an unconditional jump occurs (j=111) and old A[PC_W-1:0] == pc.
  - Once set it stays 1 until reset; pc behaviour is unchanged (self-loop).
- When undefined: no halted port and no extra logic.

Decomposition:
- Shared package/include hack_pkg holding:
  - instruction field bit positions (I_TYPE=15, I_A=12, I_C_HI=11, I_C_LO=6, I_D_HI=5, I_D_LO=3, I_J_HI=2, I_J_LO=0).
  - widths WORD_W=16 and PC_W=15.
- Sub-module hack_pc: PC_W-bit register with priority reset > load > inc.
- The existing ALU is instantiated as-is.

Test Plan:
- Reset and A-load: reset=1 for 2 cycles with instruction=16'hFFFF → writeM=0 throughout, pc=0. After release, @21 (16'h0015) → A=21, addressM=21, pc=1.
- D=A then M=D+1:
  - @21, then D=A (16'hEC10) → D=21.
  - Then M=D+1 (16'hE7C8) → outM=22, writeM=1, addressM=21.
- AM=M-1 conflict: A=5, inM=9, AM=M-1 (16'hFCA8) → outM=8, writeM=1, addressM=5 during the cycle; A=8 after the edge.
- Conditional jumps with A=100:
  - D=0, D;JEQ (16'hE302) → pc=100.
  - D=-1, D;JGT (16'hE301) → pc=old pc+1.
  - D=-1, D;JLT (16'hE304) → pc=100.
- Jump plus A write: A=40, AM... A=-1;JMP (16'hEEA7) → pc=40, A=16'hFFFF.
- Wrap and halt:
  - Force pc to 32767 with a no-op C-instruction → pc=0 next.
  - With HACK_CPU_HALT_DETECT_EN: A=pc, then 0;JMP (16'hEA87) at address A → halted=1 and pc constant.
  - Assert reset → halted=0, pc=0.
